// File: rtl/mant_div_seq.sv
// Sequential restoring divider for single-precision significands.
// Ports: clk, reset (sync, active-high), start, a_operand/b_operand {exp[30:23], mant[22:0]},
//        busy, done (one-cycle pulse), normalised, special, quotient_mantissa[22:0].
module mant_div_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [30:0] a_operand,
    input  logic [30:0] b_operand,
    output logic        busy,
    output logic        done,
    output logic        normalised,
    output logic        special,
    output logic [22:0] quotient_mantissa
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [25:0] r_rem;
    logic [23:0] r_div;
    logic [25:0] r_q;
    logic        r_busy;
    logic        r_done;
    logic        r_norm;
    logic        r_special;
    logic [22:0] r_qm;

    logic        w_accept;
    logic        w_in_special;
    logic [23:0] w_sig_a;
    logic [23:0] w_sig_b;
    logic        w_ge;
    logic [25:0] w_diff;
    logic [25:0] w_sel;
    logic [25:0] w_rem_next;
    logic [25:0] w_q_next;
    logic        w_norm;
    logic [22:0] w_mant;
    logic        w_guard;
    logic        w_sticky;
    logic [22:0] w_qm;

    assign w_accept     = start && (r_state != CALC);
    assign w_in_special = (a_operand[30:23] == 8'd0) || (b_operand[30:23] == 8'd0);
    assign w_sig_a      = {1'b1, a_operand[22:0]};
    assign w_sig_b      = {1'b1, b_operand[22:0]};

    // One restoring step: compare, conditionally subtract, then shift.
    assign w_ge       = r_rem >= {2'b00, r_div};
    assign w_diff     = r_rem - {2'b00, r_div};
    assign w_sel      = w_ge ? w_diff : r_rem;
    assign w_rem_next = {w_sel[24:0], 1'b0};
    assign w_q_next   = {r_q[24:0], w_ge};

    // Rounding is evaluated on the final step's results so DONE can
    // register them directly.
    always_comb begin
        w_norm   = w_q_next[25];
        w_mant   = w_q_next[23:1];
        w_guard  = w_q_next[0];
        w_sticky = |w_rem_next;
        if (w_q_next[25]) begin
            w_mant   = w_q_next[24:2];
            w_guard  = w_q_next[1];
            w_sticky = w_q_next[0] | (|w_rem_next);
        end
    end

    // Carry out of the round-up is dropped.
    assign w_qm = w_mant + {22'd0, (w_guard & w_sticky)};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= 5'd0;
            r_rem     <= 26'd0;
            r_div     <= 24'd0;
            r_q       <= 26'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_norm    <= 1'b0;
            r_special <= 1'b0;
            r_qm      <= 23'd0;
        end else begin
            case (r_state)
                CALC: begin
                    r_rem <= w_rem_next;
                    r_q   <= w_q_next;
                    if (r_cnt == 5'd25) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_norm  <= w_norm;
                        r_qm    <= w_qm;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_cnt <= 5'd0;
                        r_q   <= 26'd0;
                        r_div <= w_sig_b;
                        r_rem <= {2'b00, w_sig_a};
                        r_norm <= 1'b0;
                        r_qm   <= 23'd0;
                        r_special <= w_in_special;
                        if (w_in_special) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= CALC;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end
                    end else begin
                        r_state <= IDLE;
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign busy              = r_busy;
    assign done              = r_done;
    assign normalised        = r_norm;
    assign special           = r_special;
    assign quotient_mantissa = r_qm;

endmodule

// File: tb/tb_mant_div_seq.sv
// Testbench for mant_div_seq: directed and random divisions checked
// against an arithmetic reference through a scoreboard queue.
module tb_mant_div_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [30:0] a_operand;
    logic [30:0] b_operand;
    logic        busy;
    logic        done;
    logic        normalised;
    logic        special;
    logic [22:0] quotient_mantissa;

    int checks;
    int failures;

    typedef struct {
        logic        n;
        logic        sp;
        logic [22:0] m;
        int          lat;
    } exp_t;

    exp_t sb[$];

    mant_div_seq dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .a_operand         (a_operand),
        .b_operand         (b_operand),
        .busy              (busy),
        .done              (done),
        .normalised        (normalised),
        .special           (special),
        .quotient_mantissa (quotient_mantissa)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: quotient scaled by 2^25 via integer division.
    function automatic exp_t model(input logic [30:0] a, input logic [30:0] b);
        exp_t        e;
        logic [63:0] num;
        logic [63:0] q;
        logic [63:0] r;
        logic [22:0] mant;
        logic        g;
        logic        s;
        e.n = 1'b0;
        e.sp = 1'b0;
        e.m = 23'd0;
        e.lat = 1;
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) begin
            e.sp = 1'b1;
            return e;
        end
        num = {15'd0, 1'b1, a[22:0], 25'd0};
        q = num / {40'd0, 1'b1, b[22:0]};
        r = num % {40'd0, 1'b1, b[22:0]};
        if (q[25]) begin
            mant = q[24:2];
            g = q[1];
            s = q[0] | (r != 0);
        end else begin
            mant = q[23:1];
            g = q[0];
            s = (r != 0);
        end
        e.n = q[25];
        e.m = mant + {22'd0, (g & s)};
        e.lat = 27;
        return e;
    endfunction

    // Waits for done; n counts cycles from the accepting edge.
    task automatic wait_done(input int n0, output int n, output bit ok);
        n = n0;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        ok = done;
    endtask

    task automatic check_out(input string tag, input int n, input bit ok);
        exp_t e;
        if (!ok) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_lat"}, n, e.lat);
        chk({tag, "_norm"}, {31'd0, normalised}, {31'd0, e.n});
        chk({tag, "_spec"}, {31'd0, special}, {31'd0, e.sp});
        chk({tag, "_mant"}, {9'd0, quotient_mantissa}, {9'd0, e.m});
    endtask

    task automatic run_op(input string tag, input logic [30:0] a, input logic [30:0] b);
        int n;
        bit ok;
        exp_t e;
        @(negedge clk);
        a_operand = a;
        b_operand = b;
        start = 1'b1;
        e = model(a, b);
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        a_operand = ~a;
        b_operand = ~b;
        if (!e.sp) chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        wait_done(1, n, ok);
        check_out(tag, n, ok);
    endtask

    initial begin
        int n;
        bit ok;
        bit saw;
        logic [30:0] ra;
        logic [30:0] rb;
        exp_t e;
        checks = 0;
        failures = 0;
        reset = 1'b1;
        start = 1'b0;
        a_operand = 31'd0;
        b_operand = 31'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_norm", {31'd0, normalised}, 32'd0);
        chk("rst_spec", {31'd0, special}, 32'd0);
        chk("rst_mant", {9'd0, quotient_mantissa}, 32'd0);
        reset = 1'b0;

        run_op("d15_10", 31'h3FC00000, 31'h3F800000);
        chk("d15_10_abs", {9'd0, quotient_mantissa}, 32'h400000);
        run_op("d10_15", 31'h3F800000, 31'h3FC00000);
        chk("d10_15_abs", {9'd0, quotient_mantissa}, 32'h2AAAAB);
        run_op("dmax_10", 31'h3FFFFFFF, 31'h3F800000);
        chk("dmax_10_abs", {9'd0, quotient_mantissa}, 32'h7FFFFF);
        run_op("spec_b", 31'h3F800000, 31'h00000001);
        run_op("spec_a", 31'h007FFFFF, 31'h3F800000);
        run_op("d10_max", 31'h3F800000, 31'h3FFFFFFF);

        for (int i = 0; i < 6; i++) begin
            ra = {8'($urandom_range(1, 254)), 23'($urandom)};
            rb = {8'($urandom_range(1, 254)), 23'($urandom)};
            run_op($sformatf("rnd%0d", i), ra, rb);
        end

        // Abort mid-CALC with reset, start held to show reset dominates.
        @(negedge clk);
        a_operand = 31'h3FC00000;
        b_operand = 31'h3F800000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        start = 1'b0;
        saw = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done) saw = 1'b1;
        end
        chk("abort_no_done", {31'd0, saw}, 32'd0);
        run_op("post_abort", 31'h3F800000, 31'h3F800000);
        chk("post_abort_abs", {9'd0, quotient_mantissa}, 32'h0);

        // Start held through CALC, then back-to-back accept in DONE.
        @(negedge clk);
        a_operand = 31'h3F800000;
        b_operand = 31'h3FC00000;
        start = 1'b1;
        e = model(31'h3F800000, 31'h3FC00000);
        sb.push_back(e);
        @(posedge clk);
        #1;
        a_operand = 31'h3FFFFFFF;
        b_operand = 31'h3F800000;
        wait_done(1, n, ok);
        check_out("b2b_first", n, ok);
        sb.push_back(model(31'h3FFFFFFF, 31'h3F800000));
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        chk("b2b_done_low", {31'd0, done}, 32'd0);
        wait_done(1, n, ok);
        check_out("b2b_second", n, ok);
        @(posedge clk);
        #1;
        chk("idle_done_low", {31'd0, done}, 32'd0);
        chk("idle_hold_mant", {9'd0, quotient_mantissa}, 32'h7FFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mant_div_seq.md
MANT_DIV_SEQ -- requirements
Module: mant_div_seq

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed to single-precision (23-bit stored mantissa, 8-bit exponent field).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled only when the block is ready.
REQ-005 a_operand  input  31  dividend {exponent[30:23], mantissa[22:0]}.
REQ-006 b_operand  input  31  divisor {exponent[30:23], mantissa[22:0]}.
REQ-007 busy  output  1  high while a division is in progress (state CALC).
REQ-008 done  output  1  one-cycle pulse; result outputs are valid from this cycle.
REQ-009 normalised  output  1  high when the significand quotient is >= 1.0; exponent logic subtracts 1 when it is low.
REQ-010 special  output  1  high when either operand has a zero exponent field (zero or denormal).
REQ-011 quotient_mantissa  output  23  rounded 23-bit quotient mantissa, hidden bit dropped.

Function
REQ-012 The hidden bit SHALL be 1 when the operand exponent field is non-zero; the significand is {hidden, mantissa}, 24 bits.
REQ-013 FSM states SHALL be IDLE, CALC and DONE; the reset state is IDLE.
REQ-014 start SHALL be accepted in IDLE or DONE (back-to-back); it is ignored in CALC.
REQ-015 On acceptance, operands SHALL be registered, and later input changes SHALL NOT affect the result.
REQ-016 If the accepted operands are special, the FSM SHALL go directly to DONE, with special=1, normalised=0 and quotient_mantissa=0.
REQ-017 Otherwise the FSM SHALL enter CALC, with remainder = dividend significand (26-bit register), divisor = divisor significand, and the quotient cleared.
REQ-018 Each CALC cycle SHALL perform one restoring step:
- if remainder >= divisor, subtract the divisor and shift in quotient bit 1, else shift in 0;
- then shift the remainder left by 1.
REQ-019 CALC SHALL last exactly 26 cycles, producing q[25] (integer bit) down to q[0].
REQ-020 The iteration counter SHALL count 0..25 and SHALL NOT wrap; it moves the FSM CALC->DONE after the step with count 25.
REQ-021 Rounding fields, selected by q[25]:
- q[25]=1: normalised=1, mant=q[24:2], guard=q[1], sticky=q[0] | (remainder!=0).
- q[25]=0: normalised=0, mant=q[23:1], guard=q[0], sticky=(remainder!=0).
REQ-022 quotient_mantissa SHALL equal (mant + (guard & sticky)) modulo 2^23; the rounding carry-out is discarded.
REQ-023 Outputs normalised, special and quotient_mantissa SHALL be registered on entry to DONE and held until the next accepted start or reset.
REQ-024 done SHALL be high only in the DONE cycle; DONE returns to IDLE unless start is high.
REQ-025 Latency from the start-sampling edge to done high SHALL be 27 cycles for normal operands and 1 cycle for special operands.

Reset
REQ-026 reset SHALL force IDLE, clear the counter, remainder and quotient, and drive busy=0, done=0, normalised=0, special=0 and quotient_mantissa=0 on the next edge.
REQ-027 reset asserted mid-CALC SHALL abort the operation with no done pulse, and reset SHALL dominate a simultaneous start.

Verification
REQ-028 a=0x3FC00000 (1.5), b=0x3F800000 (1.0) -> done at cycle 27, normalised=1, quotient_mantissa=0x400000, special=0.
REQ-029 a=0x3F800000 (1.0), b=0x3FC00000 (1.5) -> normalised=0, quotient_mantissa=0x2AAAAB (guard=1, sticky=1, rounded up).
REQ-030 a=0x3FFFFFFF, b=0x3F800000 -> normalised=1, quotient_mantissa=0x7FFFFF, exact with no round-up.
REQ-031 b exponent field=0 (b=0x00000001), a=0x3F800000 -> done 1 cycle after start, special=1, quotient_mantissa=0, normalised=0.
REQ-032 reset at CALC cycle 10 -> busy=0 and done=0 next cycle, no done pulse; a fresh 1.0/1.0 division then gives normalised=1, quotient_mantissa=0.
REQ-033 start held high through CALC, then a new start in the DONE cycle -> mid-CALC starts ignored; the second operation is accepted back-to-back and busy rises the next cycle.
